// File: rtl/key_scan_entry.sv
// key_scan_entry: 4x4 keypad row scanner with sweep debounce, single-key entry FSM and six-digit shift register
module key_scan_entry #(
  parameter int SCAN_DIV = 25000,
  parameter int DEB_SWEEPS = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [23:0] data
);
  typedef enum logic [1:0] {IDLE, HELD, MULTI} state_t;
  state_t state, next;
  logic [3:0] col_m, col_s, stable, stable_n, idx;
  logic [14:0] cnt;
  logic [1:0] r;
  logic [15:0] snap, prev, deb, full;
  logic tick, ld, one, strobe;
  assign tick = cnt == 15'(SCAN_DIV - 1);
  assign full = {~col_s, snap[11:0]};
  assign stable_n = full == prev ? (stable == 4'(DEB_SWEEPS - 1) ? stable : stable + 4'd1) : 4'd0;
  assign one = deb != 16'd0 && (deb & (deb - 16'd1)) == 16'd0;
  assign row = ~(4'b0001 << r);
  assign key_down = state == HELD;
  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < 16; i++) if (deb[i]) idx = 4'(i);
  end
  always_comb begin
    next = state;
    strobe = 1'b0;
    if (ld) begin
      if (deb == 16'd0) next = IDLE;
      else if (state == IDLE) begin
        next = one ? HELD : MULTI;
        strobe = one;
      end else if (state == HELD) next = one && idx == key_code ? HELD : MULTI;
    end
  end
  always_ff @(posedge sys_clk) state <= !sys_rst_n ? IDLE : next;
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      cnt <= '0;
      r <= '0;
      snap <= '0;
      prev <= '0;
      deb <= '0;
      stable <= '0;
      ld <= 1'b0;
      key_valid <= 1'b0;
      key_code <= '0;
      data <= '0;
    end else begin
      col_m <= col;
      col_s <= col_m;
      cnt <= tick ? 15'd0 : cnt + 15'd1;
      ld <= 1'b0;
      if (tick) begin
        r <= r + 2'd1;
        snap[{r, 2'b00} +: 4] <= ~col_s;
        if (r == 2'd3) begin
          prev <= full;
          stable <= stable_n;
          if (stable_n == 4'(DEB_SWEEPS - 1)) begin
            deb <= full;
            ld <= 1'b1;
          end
        end
      end
      key_valid <= strobe;
      if (strobe) begin
        key_code <= idx;
        data <= {data[19:0], idx};
      end
    end
  end
endmodule
